// File: rtl/mul_tree_pipe_if.sv
// Operand-set / product stream bundle for mul_tree_pipe; the master drives operands and out_ready.
// Both directions use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface mul_tree_pipe_if #(
    parameter int NUM_OPS = 4,
    parameter int IN_W    = 10,
    parameter int TAG_W   = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_OPS*IN_W-1:0] in_ops;
    logic                    in_signed;
    logic [TAG_W-1:0]        in_tag;
    logic                    out_valid;
    logic                    out_ready;
    logic [NUM_OPS*IN_W-1:0] out_data;
    logic                    out_signed;
    logic [TAG_W-1:0]        out_tag;

    modport master (
        output in_valid, in_ops, in_signed, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_signed, out_tag
    );

    modport slave (
        input  in_valid, in_ops, in_signed, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_signed, out_tag
    );
endinterface

// File: rtl/mul_tree_pipe.sv
// Pipelined binary-tree product of NUM_OPS operands; latency log2(NUM_OPS) cycles.
// One global advance enable: the whole pipe freezes while a result is stalled, so in_ready = !out_valid | out_ready.
module mul_tree_pipe #(
    parameter int NUM_OPS = 4,
    parameter int IN_W    = 10,
    parameter int TAG_W   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_tree_pipe_if.slave bus
);
    localparam int L = $clog2(NUM_OPS);
    localparam int W = NUM_OPS * IN_W;

    logic                  en;
    logic [L:1][W-1:0]     dat_q;
    logic [L:1][W-1:0]     dat_d;
    logic [L:1]            vld_q;
    logic [L:1]            sgn_q;
    logic [L:1][TAG_W-1:0] tag_q;

    assign en           = !vld_q[L] || bus.out_ready;
    assign bus.in_ready = en;

    // Every stage is exactly W bits wide: half as many products, each twice as wide.
    for (genvar s = 1; s <= L; s++) begin : g_stage
        localparam int HW = IN_W << (s - 1);
        localparam int PW = IN_W << s;

        logic [W-1:0] src;
        logic         src_sgn;

        if (s == 1) begin : g_src_in
            assign src     = bus.in_ops;
            assign src_sgn = bus.in_signed;
        end else begin : g_src_reg
            assign src     = dat_q[s-1];
            assign src_sgn = sgn_q[s-1];
        end

        for (genvar j = 0; j < (NUM_OPS >> s); j++) begin : g_mul
            logic [HW-1:0] a;
            logic [HW-1:0] b;
            logic [PW-1:0] a_x;
            logic [PW-1:0] b_x;

            assign a   = src[2*j*HW +: HW];
            assign b   = src[(2*j+1)*HW +: HW];
            // Low PW bits of the extended product are exact in both modes since PW = 2*HW.
            assign a_x = src_sgn ? {{HW{a[HW-1]}}, a} : {{HW{1'b0}}, a};
            assign b_x = src_sgn ? {{HW{b[HW-1]}}, b} : {{HW{1'b0}}, b};
            assign dat_d[s][j*PW +: PW] = a_x * b_x;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dat_q <= '0;
            vld_q <= '0;
            sgn_q <= '0;
            tag_q <= '0;
        end else if (en) begin
            dat_q    <= dat_d;
            vld_q[1] <= bus.in_valid;
            sgn_q[1] <= bus.in_signed;
            tag_q[1] <= bus.in_tag;
            for (int s = 2; s <= L; s++) begin
                vld_q[s] <= vld_q[s-1];
                sgn_q[s] <= sgn_q[s-1];
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign bus.out_valid  = vld_q[L];
    assign bus.out_data   = dat_q[L];
    assign bus.out_signed = sgn_q[L];
    assign bus.out_tag    = tag_q[L];
endmodule

// File: tb/tb_mul_tree_pipe.sv
// Randomised and directed checks of mul_tree_pipe at three parameter points against a plain-arithmetic product model.
module tb_mul_tree_pipe;
    typedef struct {
        longint     d;
        logic       s;
        logic [7:0] t;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mul_tree_pipe_if #(.NUM_OPS(4),  .IN_W(10), .TAG_W(8)) a_if ();
    mul_tree_pipe_if #(.NUM_OPS(2),  .IN_W(4),  .TAG_W(8)) b_if ();
    mul_tree_pipe_if #(.NUM_OPS(16), .IN_W(3),  .TAG_W(8)) c_if ();

    mul_tree_pipe #(.NUM_OPS(4),  .IN_W(10), .TAG_W(8)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
    mul_tree_pipe #(.NUM_OPS(2),  .IN_W(4),  .TAG_W(8)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
    mul_tree_pipe #(.NUM_OPS(16), .IN_W(3),  .TAG_W(8)) u_c (.clk(clk), .rst_n(rst_n), .bus(c_if));

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Exact product of n operands of w bits, each read as two's complement when sgn is set.
    function automatic longint ref_prod(input logic [63:0] ops, input int n, input int w, input bit sgn);
        longint p;
        longint v;
        p = 1;
        for (int k = 0; k < n; k++) begin
            v = longint'((ops >> (k * w)) & ((64'd1 << w) - 64'd1));
            if (sgn && v[w-1]) v = v - (longint'(1) << w);
            p = p * v;
        end
        return p;
    endfunction

    task automatic idle_all();
        a_if.in_valid = 0; a_if.in_ops = '0; a_if.in_signed = 0; a_if.in_tag = '0; a_if.out_ready = 1;
        b_if.in_valid = 0; b_if.in_ops = '0; b_if.in_signed = 0; b_if.in_tag = '0; b_if.out_ready = 1;
        c_if.in_valid = 0; c_if.in_ops = '0; c_if.in_signed = 0; c_if.in_tag = '0; c_if.out_ready = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        a_if.out_ready = 0;
        repeat (3) step();
        @(negedge clk);
        n_vec++; if (a_if.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", a_if.out_valid); end
        n_vec++; if (a_if.out_data !== 40'd0) begin n_err++; $display("FAIL rst_out_data: got %h want 0", a_if.out_data); end
        n_vec++; if (a_if.out_signed !== 1'b0) begin n_err++; $display("FAIL rst_out_signed: got %b want 0", a_if.out_signed); end
        n_vec++; if (a_if.out_tag !== 8'd0) begin n_err++; $display("FAIL rst_out_tag: got %h want 0", a_if.out_tag); end
        n_vec++; if (a_if.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", a_if.in_ready); end
        n_vec++; if (b_if.out_valid !== 1'b0 || c_if.out_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_sweep_valid: got %b/%b want 0/0", b_if.out_valid, c_if.out_valid);
        end
        step();
        rst_n = 1;
        a_if.out_ready = 1;
        step();
    endtask

    task automatic test_unsigned_max();
        a_if.in_ops = {4{10'd1023}}; a_if.in_tag = 8'h5A; a_if.in_signed = 0; a_if.in_valid = 1; a_if.out_ready = 1;
        @(negedge clk);
        n_vec++; if (a_if.in_ready !== 1'b1) begin n_err++; $display("FAIL umax_in_ready: got %b want 1", a_if.in_ready); end
        step();
        a_if.in_valid = 0;
        @(negedge clk);
        n_vec++; if (a_if.out_valid !== 1'b0) begin n_err++; $display("FAIL umax_early: got %b want 0", a_if.out_valid); end
        step();
        @(negedge clk);
        n_vec++; if (a_if.out_valid !== 1'b1) begin n_err++; $display("FAIL umax_valid: got %b want 1", a_if.out_valid); end
        n_vec++; if (a_if.out_data !== 40'd1095222947841) begin n_err++; $display("FAIL umax_data: got %0d want 1095222947841", a_if.out_data); end
        n_vec++; if (a_if.out_tag !== 8'h5A || a_if.out_signed !== 1'b0) begin
            n_err++; $display("FAIL umax_side: got tag %h sgn %b want 5a 0", a_if.out_tag, a_if.out_signed);
        end
        step();
    endtask

    task automatic test_signed();
        logic [39:0] ops_t [3];
        logic [39:0] want_d [3];
        logic        sgn_t [3];
        int          got = 0;
        ops_t[0] = {4{10'h200}};                      want_d[0] = 40'd68719476736; sgn_t[0] = 1;
        ops_t[1] = {10'd1, 10'd1, 10'd1, 10'h3FF};    want_d[1] = 40'hFF_FFFF_FFFF; sgn_t[1] = 1;
        ops_t[2] = {10'd1, 10'd1, 10'd1, 10'h3FF};    want_d[2] = 40'd1023;        sgn_t[2] = 0;
        a_if.out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            a_if.in_valid = (i < 3);
            if (i < 3) begin
                a_if.in_ops = ops_t[i]; a_if.in_signed = sgn_t[i]; a_if.in_tag = 8'(i + 1);
            end
            @(negedge clk);
            if (a_if.out_valid && got < 3) begin
                n_vec++;
                if (a_if.out_data !== want_d[got] || a_if.out_signed !== sgn_t[got] || a_if.out_tag !== 8'(got + 1)) begin
                    n_err++;
                    $display("FAIL signed_%0d: got %h/%b/%h want %h/%b/%h", got, a_if.out_data, a_if.out_signed,
                             a_if.out_tag, want_d[got], sgn_t[got], 8'(got + 1));
                end
                got++;
            end
            step();
        end
        n_vec++; if (got != 3) begin n_err++; $display("FAIL signed_count: got %0d want 3", got); end
    endtask

    task automatic test_backpressure();
        int          q[$];
        int          sent = 0;
        int          got = 0;
        int          k;
        bit          p_stall = 0;
        logic [39:0] p_dat = '0;
        logic [7:0]  p_tag = '0;
        for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
            a_if.in_valid  = (sent < 8);
            a_if.in_ops    = {10'd1, 10'd3, 10'd2, 10'(sent + 1)};
            a_if.in_tag    = 8'(sent + 1);
            a_if.in_signed = sent[0];
            a_if.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (p_stall) begin
                n_vec++;
                if (a_if.out_valid !== 1'b1 || a_if.out_data !== p_dat || a_if.out_tag !== p_tag) begin
                    n_err++; $display("FAIL bp_stable: got %b/%h/%h want 1/%h/%h", a_if.out_valid, a_if.out_data, a_if.out_tag, p_dat, p_tag);
                end
            end
            if (a_if.out_valid && a_if.out_ready) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL bp_extra: got %h want none", a_if.out_data);
                end else begin
                    k = q.pop_front();
                    if (a_if.out_data !== 40'(6 * k) || a_if.out_tag !== 8'(k) || a_if.out_signed !== 1'((k - 1) & 1)) begin
                        n_err++; $display("FAIL bp_data: got %0d/%h want %0d/%h", a_if.out_data, a_if.out_tag, 6 * k, k);
                    end
                end
                got++;
            end
            p_stall = a_if.out_valid && !a_if.out_ready;
            p_dat   = a_if.out_data;
            p_tag   = a_if.out_tag;
            if (a_if.in_valid && a_if.in_ready) begin
                q.push_back(sent + 1);
                sent++;
            end
            step();
        end
        a_if.in_valid = 0;
        a_if.out_ready = 1;
        n_vec++; if (got != 8) begin n_err++; $display("FAIL bp_count: got %0d want 8", got); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++; if (a_if.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_dup: got valid %b want 0", a_if.out_valid); end
            step();
        end
    endtask

    task automatic test_reset_mid();
        a_if.out_ready = 0;
        a_if.in_ops = {4{10'd5}}; a_if.in_signed = 1; a_if.in_tag = 8'hC3; a_if.in_valid = 1;
        repeat (2) step();
        a_if.in_valid = 0;
        repeat (2) step();
        rst_n = 0;
        step();
        rst_n = 1;
        @(negedge clk);
        n_vec++; if (a_if.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", a_if.out_valid); end
        n_vec++; if (a_if.out_data !== 40'd0) begin n_err++; $display("FAIL rmid_data: got %h want 0", a_if.out_data); end
        n_vec++; if (a_if.out_tag !== 8'd0) begin n_err++; $display("FAIL rmid_tag: got %h want 0", a_if.out_tag); end
        n_vec++; if (a_if.in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_in_ready: got %b want 1", a_if.in_ready); end
        step();
        a_if.out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_vec++; if (a_if.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_stale: got valid %b want 0", a_if.out_valid); end
            step();
        end
    endtask

    task automatic test_bubbles();
        bit [7:0]    inv = 8'b0000_0101;
        bit          want_v;
        longint      q[$];
        logic [39:0] ops;
        a_if.out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            ops = 40'({$urandom(), $urandom()});
            a_if.in_valid = inv[i]; a_if.in_ops = ops; a_if.in_signed = 0; a_if.in_tag = 8'(i);
            @(negedge clk);
            want_v = (i >= 2) ? inv[i-2] : 1'b0;
            n_vec++; if (a_if.out_valid !== want_v) begin n_err++; $display("FAIL bub_valid_%0d: got %b want %b", i, a_if.out_valid, want_v); end
            if (a_if.out_valid && q.size() > 0) begin
                n_vec++;
                if (a_if.out_data !== 40'(q[0])) begin n_err++; $display("FAIL bub_data: got %h want %h", a_if.out_data, 40'(q[0])); end
                void'(q.pop_front());
            end
            if (a_if.in_valid && a_if.in_ready) q.push_back(ref_prod(64'(ops), 4, 10, 0));
            step();
        end
    endtask

    task automatic test_throughput();
        exp_t        q[$];
        exp_t        e;
        int          sent = 0;
        int          got = 0;
        logic [39:0] ops;
        a_if.out_ready = 1;
        for (int i = 0; i < 110; i++) begin
            ops = 40'({$urandom(), $urandom()});
            a_if.in_valid = (i < 100); a_if.in_ops = ops; a_if.in_signed = 1'($urandom_range(0, 1)); a_if.in_tag = 8'($urandom);
            @(negedge clk);
            if (a_if.out_valid) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL tput_extra: got %h want none", a_if.out_data);
                end else begin
                    e = q.pop_front();
                    if (a_if.out_data !== 40'(e.d) || a_if.out_signed !== e.s || a_if.out_tag !== e.t) begin
                        n_err++; $display("FAIL tput_data: got %h/%b/%h want %h/%b/%h", a_if.out_data, a_if.out_signed, a_if.out_tag, 40'(e.d), e.s, e.t);
                    end
                end
                got++;
            end
            if (a_if.in_valid && a_if.in_ready) begin
                e.d = ref_prod(64'(ops), 4, 10, a_if.in_signed); e.s = a_if.in_signed; e.t = a_if.in_tag;
                q.push_back(e);
                sent++;
            end
            step();
        end
        n_vec++; if (sent != 100) begin n_err++; $display("FAIL tput_accept: got %0d want 100", sent); end
        n_vec++; if (got != 100) begin n_err++; $display("FAIL tput_results: got %0d want 100", got); end
    endtask

    task automatic test_random_mixed();
        exp_t        q[$];
        exp_t        e;
        int          sent = 0;
        int          got = 0;
        logic [39:0] ops = '0;
        logic        sg = 0;
        logic [7:0]  tg = '0;
        bit          v = 0;
        bit          need = 1;
        for (int cyc = 0; cyc < 340; cyc++) begin
            if (need) begin
                ops = 40'({$urandom(), $urandom()});
                sg  = 1'($urandom_range(0, 1));
                tg  = 8'($urandom);
                v   = (cyc < 300) && ($urandom_range(0, 9) < 7);
                need = 0;
            end
            a_if.in_valid = v; a_if.in_ops = ops; a_if.in_signed = sg; a_if.in_tag = tg;
            a_if.out_ready = (cyc >= 300) || ($urandom_range(0, 9) < 6);
            @(negedge clk);
            n_vec++;
            if (a_if.in_ready !== (!a_if.out_valid || a_if.out_ready)) begin
                n_err++; $display("FAIL rnd_in_ready: got %b with out_valid %b out_ready %b", a_if.in_ready, a_if.out_valid, a_if.out_ready);
            end
            if (a_if.out_valid && a_if.out_ready) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL rnd_extra: got %h want none", a_if.out_data);
                end else begin
                    e = q.pop_front();
                    got++;
                    if (a_if.out_data !== 40'(e.d) || a_if.out_signed !== e.s || a_if.out_tag !== e.t) begin
                        n_err++; $display("FAIL rnd_data: got %h/%b/%h want %h/%b/%h", a_if.out_data, a_if.out_signed, a_if.out_tag, 40'(e.d), e.s, e.t);
                    end
                end
            end
            if (v && a_if.in_ready) begin
                e.d = ref_prod(64'(ops), 4, 10, sg); e.s = sg; e.t = tg;
                q.push_back(e);
                sent++;
            end
            if (!v || a_if.in_ready) need = 1;
            step();
        end
        a_if.in_valid = 0;
        n_vec++; if (got != sent || sent == 0) begin n_err++; $display("FAIL rnd_count: got %0d want %0d", got, sent); end
    endtask

    task automatic test_sweep_directed();
        b_if.in_ops = {4'h8, 4'h8}; b_if.in_signed = 1; b_if.in_tag = 8'h11; b_if.in_valid = 1; b_if.out_ready = 1;
        step();
        b_if.in_valid = 0;
        @(negedge clk);
        n_vec++; if (b_if.out_valid !== 1'b1) begin n_err++; $display("FAIL b_lat: got %b want 1", b_if.out_valid); end
        n_vec++; if (b_if.out_data !== 8'd64 || b_if.out_tag !== 8'h11) begin
            n_err++; $display("FAIL b_data: got %0d/%h want 64/11", b_if.out_data, b_if.out_tag);
        end
        step();
        @(negedge clk);
        n_vec++; if (b_if.out_valid !== 1'b0) begin n_err++; $display("FAIL b_bubble: got %b want 0", b_if.out_valid); end

        c_if.in_ops = {16{3'b111}}; c_if.in_signed = 0; c_if.in_tag = 8'h77; c_if.in_valid = 1; c_if.out_ready = 1;
        step();
        c_if.in_valid = 0;
        repeat (2) step();
        @(negedge clk);
        n_vec++; if (c_if.out_valid !== 1'b0) begin n_err++; $display("FAIL c_early: got %b want 0", c_if.out_valid); end
        step();
        @(negedge clk);
        n_vec++; if (c_if.out_valid !== 1'b1) begin n_err++; $display("FAIL c_lat: got %b want 1", c_if.out_valid); end
        n_vec++; if (c_if.out_data !== 48'd33232930569601 || c_if.out_signed !== 1'b0 || c_if.out_tag !== 8'h77) begin
            n_err++; $display("FAIL c_data: got %0d/%b/%h want 33232930569601/0/77", c_if.out_data, c_if.out_signed, c_if.out_tag);
        end
        step();
    endtask

    task automatic test_sweep_random();
        longint      qb[$];
        longint      qc[$];
        int          sb = 0, gb = 0, sc = 0, gc = 0;
        logic [7:0]  ob = '0;
        logic [47:0] oc = '0;
        logic        gsb = 0, gsc = 0;
        bit          vb = 0, vc = 0, nb = 1, nc = 1;
        for (int cyc = 0; cyc < 260; cyc++) begin
            if (nb) begin ob = 8'($urandom); gsb = 1'($urandom_range(0, 1)); vb = (cyc < 220) && ($urandom_range(0, 1) == 1); nb = 0; end
            if (nc) begin oc = 48'({$urandom(), $urandom()}); gsc = 1'($urandom_range(0, 1)); vc = (cyc < 220) && ($urandom_range(0, 1) == 1); nc = 0; end
            b_if.in_valid = vb; b_if.in_ops = ob; b_if.in_signed = gsb; b_if.out_ready = (cyc >= 220) || ($urandom_range(0, 3) != 0);
            c_if.in_valid = vc; c_if.in_ops = oc; c_if.in_signed = gsc; c_if.out_ready = (cyc >= 220) || ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (b_if.out_valid && b_if.out_ready) begin
                n_vec++;
                if (qb.size() == 0) begin n_err++; $display("FAIL b_rnd_extra: got %h want none", b_if.out_data); end
                else begin
                    gb++;
                    if (b_if.out_data !== 8'(qb[0])) begin n_err++; $display("FAIL b_rnd: got %h want %h", b_if.out_data, 8'(qb[0])); end
                    void'(qb.pop_front());
                end
            end
            if (c_if.out_valid && c_if.out_ready) begin
                n_vec++;
                if (qc.size() == 0) begin n_err++; $display("FAIL c_rnd_extra: got %h want none", c_if.out_data); end
                else begin
                    gc++;
                    if (c_if.out_data !== 48'(qc[0])) begin n_err++; $display("FAIL c_rnd: got %h want %h", c_if.out_data, 48'(qc[0])); end
                    void'(qc.pop_front());
                end
            end
            if (vb && b_if.in_ready) begin qb.push_back(ref_prod(64'(ob), 2, 4, gsb)); sb++; end
            if (vc && c_if.in_ready) begin qc.push_back(ref_prod(64'(oc), 16, 3, gsc)); sc++; end
            if (!vb || b_if.in_ready) nb = 1;
            if (!vc || c_if.in_ready) nc = 1;
            step();
        end
        b_if.in_valid = 0;
        c_if.in_valid = 0;
        n_vec++; if (gb != sb || sb == 0) begin n_err++; $display("FAIL b_rnd_count: got %0d want %0d", gb, sb); end
        n_vec++; if (gc != sc || sc == 0) begin n_err++; $display("FAIL c_rnd_count: got %0d want %0d", gc, sc); end
    endtask

    initial begin
        idle_all();
        test_reset();
        test_unsigned_max();
        test_signed();
        test_backpressure();
        test_reset_mid();
        test_bubbles();
        test_throughput();
        test_random_mixed();
        test_sweep_directed();
        test_sweep_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
